// File: rtl/lcd_char_ctrl.sv
// lcd_char_ctrl: HD44780-class character LCD write controller.
// Runs the power-on init sequence, then writes command/data bytes over valid/ready.
module lcd_char_ctrl #(
    parameter int DATA_WIDTH  = 4,
    parameter int POWERUP_CYC = 750000,
    parameter int INIT_WAIT0  = 205000,
    parameter int INIT_WAIT1  = 5000,
    parameter int CMD_WAIT    = 2000,
    parameter int CLEAR_WAIT  = 82000,
    parameter int EN_SETUP    = 2,
    parameter int EN_PULSE    = 12,
    parameter int NIB_GAP     = 50
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iValid,
    input  logic                  iRS,
    input  logic [7:0]            iData,
    output logic                  oReady,
    output logic                  oInitDone,
    output logic                  oLCD_Enabled,
    output logic                  oLCD_RS,
    output logic                  oLCD_RW,
    output logic                  oLCD_StrataFlashControl,
    output logic [DATA_WIDTH-1:0] oLCD_Data
);

    if (DATA_WIDTH != 4 && DATA_WIDTH != 8) begin : g_bad_width
        $error("lcd_char_ctrl: DATA_WIDTH must be 4 or 8");
    end

    localparam bit NIB = (DATA_WIDTH == 4);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXC = max2(max2(max2(POWERUP_CYC, INIT_WAIT0),
                                    max2(INIT_WAIT1, CMD_WAIT)),
                               max2(max2(CLEAR_WAIT, EN_SETUP),
                                    max2(EN_PULSE, NIB_GAP)));
    localparam int CW = $clog2(MAXC + 1);

    // Sequence steps: wake-ups, 4-bit switch, init commands, then user bytes
    localparam logic [3:0] ST_WAKE1 = 4'd0;
    localparam logic [3:0] ST_WAKE2 = 4'd1;
    localparam logic [3:0] ST_SET4  = 4'd3;
    localparam logic [3:0] ST_FUNC  = 4'd4;
    localparam logic [3:0] ST_CLR   = 4'd7;
    localparam logic [3:0] ST_USER  = 4'd8;

    typedef enum logic [2:0] {
        S_PWRUP, S_SETUP, S_PULSE, S_HOLD, S_GAP, S_WAIT, S_IDLE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            step_q, step_d, nxt;
    logic [7:0]            byte_q, byte_d;
    logic                  rs_q, rs_d;
    logic                  lo_q, lo_d;
    logic                  single;
    logic                  drive_d;
    logic [CW-1:0]         wlim;
    logic [DATA_WIDTH-1:0] beat_d;
    logic                  e_q, rso_q, rdy_q, done_q;
    logic [DATA_WIDTH-1:0] data_q;

    function automatic logic [7:0] step_byte(input logic [3:0] s);
        case (s)
            4'd0, 4'd1, 4'd2: return 8'h30;
            4'd3:             return 8'h20;
            4'd4:             return NIB ? 8'h28 : 8'h38;
            4'd5:             return 8'h06;
            4'd6:             return 8'h0C;
            4'd7:             return 8'h01;
            default:          return 8'h00;
        endcase
    endfunction

    // Wake-up and 4-bit switch steps send only the upper nibble in 4-bit mode
    assign single = NIB && (step_q <= ST_SET4);

    // Post-write wait length for the byte just sent
    always_comb begin
        wlim = CW'(CMD_WAIT - 1);
        if (step_q == ST_WAKE1)
            wlim = CW'(INIT_WAIT0 - 1);
        else if (step_q == ST_WAKE2)
            wlim = CW'(INIT_WAIT1 - 1);
        else if (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03))
            wlim = CW'(CLEAR_WAIT - 1);
    end

    // Next-state logic for the init sequencer and the transfer engine
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        byte_d  = byte_q;
        rs_d    = rs_q;
        lo_d    = lo_q;
        nxt     = step_q + 4'd1;
        if (!NIB && nxt == ST_SET4)
            nxt = ST_FUNC;
        unique case (state_q)
            S_PWRUP: if (cnt_q == CW'(POWERUP_CYC - 1)) begin
                state_d = S_SETUP;
                step_d  = ST_WAKE1;
                byte_d  = step_byte(ST_WAKE1);
                rs_d    = 1'b0;
                lo_d    = 1'b0;
            end
            S_SETUP: if (cnt_q == CW'(EN_SETUP - 1)) state_d = S_PULSE;
            S_PULSE: if (cnt_q == CW'(EN_PULSE - 1)) state_d = S_HOLD;
            S_HOLD:  state_d = (NIB && !single && !lo_q) ? S_GAP : S_WAIT;
            S_GAP: if (cnt_q == CW'(NIB_GAP - 1)) begin
                state_d = S_SETUP;
                lo_d    = 1'b1;
            end
            S_WAIT: if (cnt_q == wlim) begin
                if (step_q == ST_USER || step_q == ST_CLR) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SETUP;
                    step_d  = nxt;
                    byte_d  = step_byte(nxt);
                    rs_d    = 1'b0;
                    lo_d    = 1'b0;
                end
            end
            S_IDLE: if (iValid) begin
                state_d = S_SETUP;
                step_d  = ST_USER;
                byte_d  = iData;
                rs_d    = iRS;
                lo_d    = 1'b0;
            end
            default: state_d = S_PWRUP;
        endcase
    end

    // Counter restarts on every state change
    assign cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);

    // Bus value for the beat being driven next cycle
    always_comb begin
        beat_d = '0;
        if (NIB)
            beat_d = DATA_WIDTH'(lo_d ? byte_d[3:0] : byte_d[7:4]);
        else
            beat_d = DATA_WIDTH'(byte_d);
    end

    assign drive_d = (state_d == S_SETUP) || (state_d == S_PULSE) ||
                     (state_d == S_HOLD);

    // Sequencer state registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_PWRUP;
            cnt_q   <= '0;
            step_q  <= ST_WAKE1;
            byte_q  <= '0;
            rs_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            byte_q  <= byte_d;
            rs_q    <= rs_d;
            lo_q    <= lo_d;
        end
    end

    // Registered pin outputs so E and the bus never glitch
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            e_q    <= 1'b0;
            rso_q  <= 1'b0;
            data_q <= '0;
            rdy_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            e_q    <= (state_d == S_PULSE);
            rso_q  <= drive_d & rs_d;
            data_q <= drive_d ? beat_d : '0;
            rdy_q  <= (state_d == S_IDLE);
            done_q <= done_q | (state_d == S_IDLE);
        end
    end

    assign oReady                  = rdy_q;
    assign oInitDone               = done_q;
    assign oLCD_Enabled            = e_q;
    assign oLCD_RS                 = rso_q;
    assign oLCD_RW                 = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;
    assign oLCD_Data               = data_q;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// tb_lcd_char_ctrl: random traffic into 4-bit and 8-bit controllers,
// checked against a beat/timing scoreboard built from the write rules.
module tb_lcd_char_ctrl;

    localparam int PU   = 100;
    localparam int W0   = 40;
    localparam int W1   = 20;
    localparam int CMDW = 10;
    localparam int CLRW = 30;
    localparam int ES   = 2;
    localparam int EP   = 4;
    localparam int NG   = 5;
    localparam int P    = ES + EP + 1;

    typedef struct {
        int rs;
        int dat;
        int t;
    } beat_t;

    logic Clock = 1'b0;
    logic Reset;
    logic drive_en;

    logic       vi [2];
    logic       rsi[2];
    logic [7:0] di [2];

    logic       rdy4, done4, e4, lrs4, rw4, sf4;
    logic [3:0] q4;
    logic       rdy8, done8, e8, lrs8, rw8, sf8;
    logic [7:0] q8;

    logic ro[2], eo[2], lro[2], dn[2];
    int   dat_o[2];

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    acc[2] = '{0, 0};
    int    acc_t[2] = '{-1, -1};
    beat_t bq[2][$];
    int    rq[2][$];

    logic       dir_rs[3] = '{1'b1, 1'b0, 1'b0};
    logic [7:0] dir4[3]   = '{8'h41, 8'h01, 8'h80};
    logic [7:0] dir8[3]   = '{8'h5A, 8'h01, 8'h80};

    always #5 Clock = ~Clock;

    lcd_char_ctrl #(
        .DATA_WIDTH(4), .POWERUP_CYC(PU), .INIT_WAIT0(W0), .INIT_WAIT1(W1),
        .CMD_WAIT(CMDW), .CLEAR_WAIT(CLRW), .EN_SETUP(ES), .EN_PULSE(EP),
        .NIB_GAP(NG)
    ) u_dut4 (
        .Clock(Clock), .Reset(Reset), .iValid(vi[0]), .iRS(rsi[0]),
        .iData(di[0]), .oReady(rdy4), .oInitDone(done4),
        .oLCD_Enabled(e4), .oLCD_RS(lrs4), .oLCD_RW(rw4),
        .oLCD_StrataFlashControl(sf4), .oLCD_Data(q4)
    );

    lcd_char_ctrl #(
        .DATA_WIDTH(8), .POWERUP_CYC(PU), .INIT_WAIT0(W0), .INIT_WAIT1(W1),
        .CMD_WAIT(CMDW), .CLEAR_WAIT(CLRW), .EN_SETUP(ES), .EN_PULSE(EP),
        .NIB_GAP(NG)
    ) u_dut8 (
        .Clock(Clock), .Reset(Reset), .iValid(vi[1]), .iRS(rsi[1]),
        .iData(di[1]), .oReady(rdy8), .oInitDone(done8),
        .oLCD_Enabled(e8), .oLCD_RS(lrs8), .oLCD_RW(rw8),
        .oLCD_StrataFlashControl(sf8), .oLCD_Data(q8)
    );

    always_comb begin
        ro[0] = rdy4;  ro[1] = rdy8;
        eo[0] = e4;    eo[1] = e8;
        lro[0] = lrs4; lro[1] = lrs8;
        dn[0] = done4; dn[1] = done8;
        dat_o[0] = int'(q4);
        dat_o[1] = int'(q8);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Wait after a byte: clear/home commands take the long wait
    function automatic int post_wait(input int rs, input int b);
        return (rs == 0 && b >= 1 && b <= 3) ? CLRW : CMDW;
    endfunction

    // Queue the expected bus beats of one write starting its setup at t;
    // returns the cycle the last beat's hold ends
    function automatic int push_byte(input int k, input int t, input int rs,
                                     input int b, input bit single);
        beat_t x;
        x.rs = rs;
        if (k == 1) begin
            x.dat = b; x.t = t + ES; bq[k].push_back(x);
            return t + P;
        end
        x.dat = (b >> 4) & 15; x.t = t + ES; bq[k].push_back(x);
        if (single) return t + P;
        x.dat = b & 15; x.t = t + P + NG + ES; bq[k].push_back(x);
        return t + 2 * P + NG;
    endfunction

    function automatic void model_init(input int k);
        int t;
        int cmds[4];
        cmds = '{(k == 0) ? 8'h28 : 8'h38, 8'h06, 8'h0C, 8'h01};
        t = PU;
        t = push_byte(k, t, 0, 8'h30, 1'b1) + W0;
        t = push_byte(k, t, 0, 8'h30, 1'b1) + W1;
        t = push_byte(k, t, 0, 8'h30, 1'b1) + CMDW;
        if (k == 0) t = push_byte(k, t, 0, 8'h20, 1'b1) + CMDW;
        for (int i = 0; i < 4; i++)
            t = push_byte(k, t, 0, cmds[i], 1'b0) + post_wait(0, cmds[i]);
        rq[k].push_back(t);
    endfunction

    // Cycle count, acceptance tracking and scoreboard loading
    always @(posedge Clock) begin
        if (Reset) begin
            cyc = 0;
            for (int k = 0; k < 2; k++) begin
                bq[k].delete();
                rq[k].delete();
                acc_t[k] = -1;
                model_init(k);
            end
        end else begin
            cyc = cyc + 1;
            for (int k = 0; k < 2; k++) begin
                if (vi[k] && ro[k]) begin
                    int te;
                    te = push_byte(k, cyc, int'(rsi[k]), int'(di[k]), 1'b0);
                    rq[k].push_back(te + post_wait(int'(rsi[k]), int'(di[k])));
                    acc[k]++;
                    acc_t[k] = cyc;
                end
            end
        end
    end

    // Stimulus: iValid forced high while busy, directed then random bytes when ready
    always @(negedge Clock) begin
        for (int k = 0; k < 2; k++) begin
            if (!drive_en) begin
                vi[k] = 1'b0; rsi[k] = 1'b0; di[k] = 8'h00;
            end else if (!ro[k]) begin
                vi[k] = 1'b1; rsi[k] = 1'($urandom); di[k] = 8'($urandom);
            end else if (acc[k] < 3) begin
                vi[k]  = 1'b1;
                rsi[k] = dir_rs[acc[k]];
                di[k]  = (k == 0) ? dir4[acc[k]] : dir8[acc[k]];
            end else begin
                vi[k]  = 1'($urandom);
                rsi[k] = 1'($urandom);
                di[k]  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4))
                                                    : 8'($urandom);
            end
        end
    end

    // Bus monitor
    logic  ep[2], rp[2];
    int    elen[2], cur[2];
    always @(negedge Clock) begin
        for (int k = 0; k < 2; k++) begin
            if (Reset) begin
                ep[k] = 1'b0; rp[k] = 1'b0; elen[k] = 0;
            end else begin
                if (acc_t[k] == cyc)
                    check("ready_drop", ro[k], 0);
                if (eo[k] && !ep[k]) begin
                    elen[k] = 1;
                    if (bq[k].size() == 0) begin
                        check("extra_pulse", 1, 0);
                        cur[k] = dat_o[k];
                    end else begin
                        beat_t b;
                        b = bq[k].pop_front();
                        cur[k] = b.dat;
                        check("beat_rs", lro[k], b.rs);
                        check("beat_dat", dat_o[k], b.dat);
                        check("beat_time", cyc, b.t);
                    end
                end else if (eo[k]) begin
                    elen[k]++;
                    check("beat_hold", dat_o[k], cur[k]);
                end
                if (!eo[k] && ep[k])
                    check("e_width", elen[k], EP);
                if (ro[k] && !rp[k]) begin
                    if (rq[k].size() == 0)
                        check("extra_ready", 1, 0);
                    else
                        check("ready_time", cyc, rq[k].pop_front());
                    check("idle_bus", dat_o[k] + int'(lro[k]), 0);
                    check("init_done", dn[k], 1);
                end
                ep[k] = eo[k];
                rp[k] = ro[k];
            end
        end
    end

    task automatic wait_acc(input int n0, input int n1);
        int i = 0;
        while ((acc[0] < n0 || acc[1] < n1) && i < 5000) begin
            @(posedge Clock);
            i++;
        end
        check("run_timeout", (acc[0] >= n0 && acc[1] >= n1), 1);
    endtask

    initial begin
        int n;
        Reset    = 1'b1;
        drive_en = 1'b1;
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        check("rst_ready4", rdy4, 0);
        check("rst_done4", done4, 0);
        check("rst_e4", e4, 0);
        check("rst_rs4", lrs4, 0);
        check("rst_rw4", rw4, 0);
        check("rst_data4", q4, 0);
        check("rst_sf4", sf4, 1);
        check("rst_ready8", rdy8, 0);
        check("rst_e8", e8, 0);
        check("rst_data8", q8, 0);
        @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check("rel_ready4", rdy4, 0);
        check("rel_e4", e4, 0);
        check("rel_done8", done8, 0);

        wait_acc(12, 12);

        n = 0;
        while (!e4 && n < 2000) begin
            @(negedge Clock);
            n++;
        end
        check("e_seen", e4, 1);
        #2 Reset = 1'b1;
        #1;
        check("arst_e4", e4, 0);
        check("arst_rs4", lrs4, 0);
        check("arst_data4", q4, 0);
        check("arst_ready4", rdy4, 0);
        check("arst_done4", done4, 0);
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;

        wait_acc(acc[0] + 8, acc[1] + 8);
        drive_en = 1'b0;
        n = 0;
        while ((bq[0].size() + bq[1].size() + rq[0].size() + rq[1].size() != 0
                || !rdy4 || !rdy8) && n < 2000) begin
            @(negedge Clock);
            n++;
        end
        check("pending_beats4", bq[0].size(), 0);
        check("pending_beats8", bq[1].size(), 0);
        check("pending_ready4", rq[0].size(), 0);
        check("pending_ready8", rq[1].size(), 0);
        check("final_rw8", rw8, 0);
        check("final_sf8", sf8, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
